// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: op/state encodings,
// mask and lane constants, and small op-classification helpers.
package mem_stage_pkg;

    localparam int          DATA_W     = 32;
    localparam int          REG_W      = 5;
    localparam int          BYTE_W     = 8;
    localparam logic [3:0]  WMASK_FULL = 4'b1111;
    localparam logic [3:0]  WMASK_NONE = 4'b0000;

    typedef enum logic [2:0] {
        MEM_NONE = 3'd0,
        MEM_LW   = 3'd1,
        MEM_LBU  = 3'd2,
        MEM_SW   = 3'd3,
        MEM_SB   = 3'd4
    } mem_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } mem_state_e;

    function automatic logic is_store(input mem_op_e op);
        return (op == MEM_SW) || (op == MEM_SB);
    endfunction

    // Only full-word ops carry an alignment requirement; byte ops never fault.
    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lane);
        return ((op == MEM_LW) || (op == MEM_SW)) && (lane != 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: word passthrough for LW, zero-extended byte lane for LBU.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        lane,
    input  mem_op_e           op,
    output logic [DATA_W-1:0] data
);

    logic [BYTE_W-1:0] byte_sel;

    // Little-endian lane pick, then extend according to the load width.
    always_comb begin
        byte_sel = word[{lane, 3'b000} +: BYTE_W];
        data     = word;
        if (op == MEM_LBU)
            data = {{(DATA_W-BYTE_W){1'b0}}, byte_sel};
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: accepts one op at a time from execute, drives the
// data-memory request/response handshake, and emits a registered writeback.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              n_reset,
    input  logic              valid_i,
    output logic              ready_o,
    input  mem_op_e           op_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_W-1:0]  rd_addr_i,
    input  logic              rd_we_i,
    output logic              dmem_req_valid_o,
    input  logic              dmem_req_ready_i,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    output logic [3:0]        dmem_wmask_o,
    input  logic              dmem_rsp_valid_i,
    input  logic [DATA_W-1:0] dmem_rsp_data_i,
    output logic              wb_valid_o,
    output logic              wb_we_o,
    output logic [REG_W-1:0]  wb_rd_addr_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              misalign_o
);

    mem_state_e        state;
    mem_op_e           op_q;
    logic [1:0]        lane_q;
    logic [REG_W-1:0]  rd_q;
    logic [DATA_W-1:0] load_data;

    assign ready_o = (state == S_IDLE);

    load_align u_load_align (
        .word (dmem_rsp_data_i),
        .lane (lane_q),
        .op   (op_q),
        .data (load_data)
    );

    // Stage FSM; request fields and writeback record are all registered here
    // so reset clears every output, including an in-flight request.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state            <= S_IDLE;
            op_q             <= MEM_NONE;
            lane_q           <= 2'b00;
            rd_q             <= '0;
            dmem_req_valid_o <= 1'b0;
            dmem_we_o        <= 1'b0;
            dmem_addr_o      <= '0;
            dmem_wdata_o     <= '0;
            dmem_wmask_o     <= WMASK_NONE;
            wb_valid_o       <= 1'b0;
            wb_we_o          <= 1'b0;
            wb_rd_addr_o     <= '0;
            wb_data_o        <= '0;
            misalign_o       <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            misalign_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        op_q   <= op_i;
                        lane_q <= addr_i[1:0];
                        rd_q   <= rd_addr_i;
                        if (op_i == MEM_NONE) begin
                            wb_valid_o   <= 1'b1;
                            wb_we_o      <= rd_we_i;
                            wb_rd_addr_o <= rd_addr_i;
                            wb_data_o    <= addr_i;
                        end else if (is_misaligned(op_i, addr_i[1:0])) begin
                            wb_valid_o   <= 1'b1;
                            wb_we_o      <= 1'b0;
                            wb_rd_addr_o <= rd_addr_i;
                            misalign_o   <= 1'b1;
                        end else begin
                            state            <= S_REQ;
                            dmem_req_valid_o <= 1'b1;
                            dmem_we_o        <= is_store(op_i);
                            dmem_addr_o      <= {addr_i[DATA_W-1:2], 2'b00};
                            case (op_i)
                                MEM_SW: begin
                                    dmem_wmask_o <= WMASK_FULL;
                                    dmem_wdata_o <= wdata_i;
                                end
                                MEM_SB: begin
                                    dmem_wmask_o <= 4'b0001 << addr_i[1:0];
                                    dmem_wdata_o <= {4{wdata_i[BYTE_W-1:0]}};
                                end
                                default: begin
                                    dmem_wmask_o <= WMASK_NONE;
                                    dmem_wdata_o <= '0;
                                end
                            endcase
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_req_ready_i) begin
                        dmem_req_valid_o <= 1'b0;
                        if (is_store(op_q)) begin
                            state        <= S_IDLE;
                            wb_valid_o   <= 1'b1;
                            wb_we_o      <= 1'b0;
                            wb_rd_addr_o <= rd_q;
                        end else begin
                            state <= S_RSP;
                        end
                    end
                end
                S_RSP: begin
                    if (dmem_rsp_valid_i) begin
                        state        <= S_IDLE;
                        wb_valid_o   <= 1'b1;
                        wb_we_o      <= 1'b1;
                        wb_rd_addr_o <= rd_q;
                        wb_data_o    <= load_data;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs driven and outputs sampled on the
// falling edge, so each check sees the state left by the previous rising edge.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        valid_i;
    logic        ready_o;
    mem_op_e     op_i;
    logic [31:0] addr_i, wdata_i;
    logic [4:0]  rd_addr_i;
    logic        rd_we_i;
    logic        dmem_req_valid_o, dmem_req_ready_i, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_wmask_o;
    logic        dmem_rsp_valid_i;
    logic [31:0] dmem_rsp_data_i;
    logic        wb_valid_o, wb_we_o, misalign_o;
    logic [4:0]  wb_rd_addr_o;
    logic [31:0] wb_data_o;

    int errors = 0;
    int checks = 0;

    mem_stage dut (
        .clk              (clk),
        .n_reset          (n_reset),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .op_i             (op_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .rd_addr_i        (rd_addr_i),
        .rd_we_i          (rd_we_i),
        .dmem_req_valid_o (dmem_req_valid_o),
        .dmem_req_ready_i (dmem_req_ready_i),
        .dmem_we_o        (dmem_we_o),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_wmask_o     (dmem_wmask_o),
        .dmem_rsp_valid_i (dmem_rsp_valid_i),
        .dmem_rsp_data_i  (dmem_rsp_data_i),
        .wb_valid_o       (wb_valid_o),
        .wb_we_o          (wb_we_o),
        .wb_rd_addr_o     (wb_rd_addr_o),
        .wb_data_o        (wb_data_o),
        .misalign_o       (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic issue(input mem_op_e op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input logic we);
        valid_i   = 1'b1;
        op_i      = op;
        addr_i    = a;
        wdata_i   = wd;
        rd_addr_i = rd;
        rd_we_i   = we;
    endtask

    initial begin
        n_reset = 1'b0; valid_i = 1'b0; op_i = MEM_NONE; addr_i = '0; wdata_i = '0;
        rd_addr_i = '0; rd_we_i = 1'b0; dmem_req_ready_i = 1'b0;
        dmem_rsp_valid_i = 1'b0; dmem_rsp_data_i = '0;

        // reset state
        #1;
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_req_valid", {31'd0, dmem_req_valid_o}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        check("rst_misalign", {31'd0, misalign_o}, 32'd0);
        check("rst_wb_data", wb_data_o, 32'd0);
        check("rst_wmask", {28'd0, dmem_wmask_o}, 32'd0);
        cyc();
        n_reset = 1'b1;
        cyc();

        // MEM_NONE passthrough
        issue(MEM_NONE, 32'h0000_1234, 32'h0, 5'd7, 1'b1);
        check("none_ready", {31'd0, ready_o}, 32'd1);
        cyc();
        valid_i = 1'b0;
        check("none_wb_valid", {31'd0, wb_valid_o}, 32'd1);
        check("none_wb_we", {31'd0, wb_we_o}, 32'd1);
        check("none_wb_rd", {27'd0, wb_rd_addr_o}, 32'd7);
        check("none_wb_data", wb_data_o, 32'h0000_1234);
        check("none_no_req", {31'd0, dmem_req_valid_o}, 32'd0);
        cyc();
        check("none_wb_drop", {31'd0, wb_valid_o}, 32'd0);

        // SB with ready low for three cycles
        issue(MEM_SB, 32'h0000_0102, 32'hAABB_CCDD, 5'd3, 1'b0);
        cyc();
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("sb_req_valid", {31'd0, dmem_req_valid_o}, 32'd1);
            check("sb_addr", dmem_addr_o, 32'h0000_0100);
            check("sb_mask", {28'd0, dmem_wmask_o}, 32'b0100);
            check("sb_wdata", dmem_wdata_o, 32'hDDDD_DDDD);
            check("sb_we", {31'd0, dmem_we_o}, 32'd1);
            check("sb_ready_o", {31'd0, ready_o}, 32'd0);
            check("sb_no_wb", {31'd0, wb_valid_o}, 32'd0);
            if (i < 2) cyc();
        end
        dmem_req_ready_i = 1'b1;
        cyc();
        dmem_req_ready_i = 1'b0;
        check("sb_wb_valid", {31'd0, wb_valid_o}, 32'd1);
        check("sb_wb_we", {31'd0, wb_we_o}, 32'd0);
        check("sb_req_drop", {31'd0, dmem_req_valid_o}, 32'd0);
        check("sb_idle", {31'd0, ready_o}, 32'd1);
        cyc();
        check("sb_wb_drop", {31'd0, wb_valid_o}, 32'd0);

        // aligned SW with ready already high: writeback at N+2
        dmem_req_ready_i = 1'b1;
        issue(MEM_SW, 32'h0000_0010, 32'h1234_5678, 5'd2, 1'b1);
        cyc();
        valid_i = 1'b0;
        check("sw_mask", {28'd0, dmem_wmask_o}, 32'hF);
        check("sw_wdata", dmem_wdata_o, 32'h1234_5678);
        check("sw_addr", dmem_addr_o, 32'h0000_0010);
        check("sw_wb_n1", {31'd0, wb_valid_o}, 32'd0);
        cyc();
        check("sw_wb_n2", {31'd0, wb_valid_o}, 32'd1);
        check("sw_wb_we", {31'd0, wb_we_o}, 32'd0);

        // LBU; stray response during the handshake cycle must be ignored
        issue(MEM_LBU, 32'h0000_0203, 32'h0, 5'd9, 1'b0);
        cyc();
        valid_i = 1'b0;
        dmem_rsp_valid_i = 1'b1;
        dmem_rsp_data_i  = 32'hDEAD_BEEF;
        check("lbu_req_valid", {31'd0, dmem_req_valid_o}, 32'd1);
        check("lbu_addr", dmem_addr_o, 32'h0000_0200);
        check("lbu_mask", {28'd0, dmem_wmask_o}, 32'd0);
        check("lbu_we", {31'd0, dmem_we_o}, 32'd0);
        cyc();
        dmem_rsp_valid_i = 1'b0;
        check("lbu_rsp_wait_wb", {31'd0, wb_valid_o}, 32'd0);
        check("lbu_rsp_req_drop", {31'd0, dmem_req_valid_o}, 32'd0);
        check("lbu_rsp_ready", {31'd0, ready_o}, 32'd0);
        cyc();
        dmem_rsp_valid_i = 1'b1;
        dmem_rsp_data_i  = 32'h8877_6655;
        check("lbu_still_wait", {31'd0, wb_valid_o}, 32'd0);
        cyc();
        dmem_rsp_valid_i = 1'b0;
        check("lbu_wb_valid", {31'd0, wb_valid_o}, 32'd1);
        check("lbu_wb_we", {31'd0, wb_we_o}, 32'd1);
        check("lbu_wb_rd", {27'd0, wb_rd_addr_o}, 32'd9);
        check("lbu_wb_data", wb_data_o, 32'h0000_0088);
        // new op accepted in the same cycle as the load writeback
        check("b2b_ready", {31'd0, ready_o}, 32'd1);
        issue(MEM_NONE, 32'h0000_0055, 32'h0, 5'd4, 1'b0);
        cyc();
        valid_i = 1'b0;
        check("b2b_wb_valid", {31'd0, wb_valid_o}, 32'd1);
        check("b2b_wb_data", wb_data_o, 32'h0000_0055);
        check("b2b_wb_we", {31'd0, wb_we_o}, 32'd0);
        check("b2b_wb_rd", {27'd0, wb_rd_addr_o}, 32'd4);
        cyc();
        check("b2b_wb_drop", {31'd0, wb_valid_o}, 32'd0);

        // misaligned LW: no request, misalign pulse
        issue(MEM_LW, 32'h0000_0006, 32'h0, 5'd5, 1'b1);
        cyc();
        valid_i = 1'b0;
        check("mis_no_req", {31'd0, dmem_req_valid_o}, 32'd0);
        check("mis_flag", {31'd0, misalign_o}, 32'd1);
        check("mis_wb_valid", {31'd0, wb_valid_o}, 32'd1);
        check("mis_wb_we", {31'd0, wb_we_o}, 32'd0);
        cyc();
        check("mis_flag_drop", {31'd0, misalign_o}, 32'd0);
        check("mis_wb_drop", {31'd0, wb_valid_o}, 32'd0);

        // aligned LW interrupted by asynchronous reset
        dmem_req_ready_i = 1'b0;
        issue(MEM_LW, 32'h0000_0040, 32'h0, 5'd6, 1'b1);
        cyc();
        valid_i = 1'b0;
        check("lwr_req_valid", {31'd0, dmem_req_valid_o}, 32'd1);
        #2;
        n_reset = 1'b0;
        #1;
        check("lwr_async_ready", {31'd0, ready_o}, 32'd1);
        check("lwr_async_req", {31'd0, dmem_req_valid_o}, 32'd0);
        check("lwr_async_wb", {31'd0, wb_valid_o}, 32'd0);
        cyc();
        n_reset = 1'b1;
        dmem_req_ready_i = 1'b1;
        dmem_rsp_valid_i = 1'b1;
        dmem_rsp_data_i  = 32'hCAFE_F00D;
        cyc();
        dmem_rsp_valid_i = 1'b0;
        check("lwr_stray_wb", {31'd0, wb_valid_o}, 32'd0);
        check("lwr_stray_ready", {31'd0, ready_o}, 32'd1);
        cyc();
        check("lwr_stray_wb2", {31'd0, wb_valid_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
